// File: rtl/mio_pkg.sv
// Shared address map, store-strobe encodings and counter control bit positions
// for the mio_bus memory/IO slice.
package mio_pkg;

  localparam logic [31:0] ADDR_GPIO_OUT = 32'hE000_0000;
  localparam logic [31:0] ADDR_SW_IN    = 32'hE000_0004;
  localparam logic [31:0] ADDR_CNT_VAL  = 32'hF000_0000;
  localparam logic [31:0] ADDR_CNT_CTRL = 32'hF000_0004;
  localparam logic [31:0] ADDR_CNT_STAT = 32'hF000_0008;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;

  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;

  // Byte lanes touched by a RAM store; lane 0 is bits [7:0].
  function automatic logic [3:0] lane_mask(input logic [1:0] mw, input logic [1:0] a);
    case (mw)
      MW_BYTE: return 4'b0001 << a;
      MW_HALF: return a[1] ? 4'b1100 : 4'b0011;
      MW_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mio_counter.sv
// Down-counter timer with reload register, enable/auto-reload control and a
// sticky expired flag that drives the CPU interrupt.
module mio_counter
  import mio_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_b,
  input  logic        wr_val,
  input  logic        wr_ctrl,
  input  logic        wr_stat,
  input  logic [31:0] wdata,
  output logic [31:0] value,
  output logic [1:0]  ctrl,
  output logic        expired
);

  logic [31:0] reload;
  logic        tc;

  // Terminal count: the 1 -> 0 step, unless a CNT_VAL store overrides it.
  assign tc = ctrl[CTRL_EN] && (value == 32'd1) && !wr_val;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      value   <= '0;
      reload  <= '0;
      ctrl    <= '0;
      expired <= 1'b0;
    end else begin
      if (wr_val) begin
        value  <= wdata;
        reload <= wdata;
      end else if (ctrl[CTRL_EN] && (value != '0)) begin
        value <= tc ? (ctrl[CTRL_AR] ? reload : '0) : value - 32'd1;
      end

      if (wr_ctrl) ctrl <= wdata[1:0];

      if (tc)                         expired <= 1'b1;
      else if (wr_stat && wdata[0])   expired <= 1'b0;
    end
  end

endmodule

// File: rtl/mio_bus.sv
// Data-side bus for a single-cycle CPU: RAM, GPIO, switches and an optional
// interrupt timer (present only when MIO_COUNTER_EN is defined).
module mio_bus
  import mio_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int GPIO_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       Data_out,
  input  logic [1:0]        mem_w,
  output logic [31:0]       Data_in,
  input  logic [GPIO_W-1:0] sw_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              counter0_out
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   mem [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic [31:0]   wdata;
  logic [3:0]    lanes;
  logic          we;
  logic          ram_hit, gpio_hit, sw_hit, cval_hit, cctrl_hit, cstat_hit;
  logic [31:0]   cnt_value;
  logic [1:0]    cnt_ctrl;
  logic          cnt_expired;

  assign we        = (mem_w != MW_NONE);
  assign ram_hit   = (Addr_out[31:AW+2] == '0);
  assign ram_idx   = Addr_out[AW+1:2];
  assign gpio_hit  = (Addr_out == ADDR_GPIO_OUT);
  assign sw_hit    = (Addr_out == ADDR_SW_IN);
  assign cval_hit  = (Addr_out == ADDR_CNT_VAL);
  assign cctrl_hit = (Addr_out == ADDR_CNT_CTRL);
  assign cstat_hit = (Addr_out == ADDR_CNT_STAT);
  assign lanes     = lane_mask(mem_w, Addr_out[1:0]);

  // Replicate the store data so every lane sees its bytes at the right offset.
  always_comb begin
    wdata = Data_out;
    case (mem_w)
      MW_BYTE: wdata = {4{Data_out[7:0]}};
      MW_HALF: wdata = {2{Data_out[15:0]}};
      default: wdata = Data_out;
    endcase
  end

  // No reset on RAM so contents survive a CPU reset.
  always_ff @(posedge clk) begin
    if (ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                gpio_out <= '0;
    else if (we && gpio_hit)   gpio_out <= Data_out[GPIO_W-1:0];
  end

`ifdef MIO_COUNTER_EN
  mio_counter u_counter (
    .clk_sys (clk),
    .rst_b   (reset),
    .wr_val  (we && cval_hit),
    .wr_ctrl (we && cctrl_hit),
    .wr_stat (we && cstat_hit),
    .wdata   (Data_out),
    .value   (cnt_value),
    .ctrl    (cnt_ctrl),
    .expired (cnt_expired)
  );
`else
  assign cnt_value   = '0;
  assign cnt_ctrl    = '0;
  assign cnt_expired = 1'b0;
`endif

  assign counter0_out = cnt_expired;

  always_comb begin
    Data_in = '0;
    if (ram_hit)        Data_in = mem[ram_idx];
    else if (gpio_hit)  Data_in = 32'(gpio_out);
    else if (sw_hit)    Data_in = 32'(sw_in);
    else if (cval_hit)  Data_in = cnt_value;
    else if (cctrl_hit) Data_in = {30'd0, cnt_ctrl};
    else if (cstat_hit) Data_in = {31'd0, cnt_expired};
  end

endmodule

// File: doc/mio_bus.md
MIO_BUS -- requirements
Module: mio_bus

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, the number of 32-bit data RAM words (power of two).
REQ-002 SHALL have parameter GPIO_W, default 16, the width of the GPIO output and switch input.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: the reset, asynchronous and active-low.
REQ-005 SHALL have port Addr_out, input, 32: the CPU data address.
REQ-006 SHALL have port Data_out, input, 32: the CPU store data.
REQ-007 SHALL have port mem_w, input, 2: the store strobe; 00 none, 01 byte, 10 half, 11 word.
REQ-008 SHALL have port Data_in, output, 32: the read data returned to the CPU.
REQ-009 SHALL have port sw_in, input, GPIO_W: the switch inputs.
REQ-010 SHALL have port gpio_out, output, GPIO_W: the LED/GPIO register.
REQ-011 SHALL have port counter0_out, output, 1: the interrupt level that feeds the CPU INT input.

Function
REQ-012 SHALL decode the address map as follows:
- RAM: 0x0000_0000 to RAM_WORDS*4-1.
- GPIO_OUT: 0xE000_0000.
- SW_IN: 0xE000_0004 (read-only).
- CNT_VAL: 0xF000_0000.
- CNT_CTRL: 0xF000_0004 (bit0 enable, bit1 auto-reload).
- CNT_STAT: 0xF000_0008 (bit0 expired).
REQ-013 SHALL return Data_in combinationally in the same cycle as Addr_out (zero-latency read for the single-cycle CPU).
REQ-014 SHALL return the full aligned word on a read; the CPU performs any byte or half extraction.
REQ-015 SHALL return 0 for a read of an unmapped address and ignore a write to one.
REQ-016 SHALL commit writes on the clock edge when mem_w is not 00.
REQ-017 SHALL select byte-write lanes as follows:
- byte: Addr_out[1:0] selects the lane and writes Data_out[7:0].
- half: Addr_out[1] selects the lane and writes Data_out[15:0]; Addr_out[0] is ignored.
- word: Addr_out[1:0] is ignored.
REQ-018 SHALL treat any non-00 mem_w to a register address as a full 32-bit write; the register keeps its low bits.
REQ-019 SHALL, on a CNT_VAL write, load both the reload register and the counter value.
REQ-020 SHALL, while enable=1 and value>0, decrement the counter value by 1 each cycle.
REQ-021 SHALL, on the cycle value goes from 1 toward 0, set expired and then:
- with auto-reload=1: load the reload value instead of 0;
- with auto-reload=0: hold 0.
REQ-022 SHALL let a CNT_VAL write win over a same-cycle decrement.
REQ-023 SHALL clear CNT_STAT bit0 when written with 1, and let a same-cycle new expiry win (bit stays 1).
REQ-024 SHALL drive counter0_out equal to expired, held until cleared.
REQ-025 SHALL make a CNT_VAL read return the live count.
REQ-026 SHALL hold the count at 0 with no expiry when reload=0 and auto-reload=1.

Reset
REQ-027 SHALL, on reset low, immediately clear gpio_out, the counter value, the reload register, CNT_CTRL, expired and counter0_out to 0.
REQ-028 SHALL leave RAM contents unaffected by reset.
REQ-029 SHALL let reset asserted mid-countdown abort the countdown with no expiry.

Configuration
REQ-030 SHALL, with MIO_COUNTER_EN defined, implement REQ-019 to REQ-026.
REQ-031 SHALL, with MIO_COUNTER_EN undefined, omit the counter logic; CNT_* reads return 0, writes to them are ignored, and counter0_out is tied 0.

Structure
REQ-032 SHALL place in shared package mio_pkg: the address-map constants, mem_w encodings (MW_NONE/MW_BYTE/MW_HALF/MW_WORD) and CNT_CTRL bit indices.
REQ-033 SHALL implement the counter (value, reload, ctrl, expired) as sub-module mio_counter, instantiated only under MIO_COUNTER_EN.
REQ-034 SHALL keep the RAM, decode and read mux in mio_bus.

Verification
REQ-035 SHALL cover a word write then read: write 0x1234_5678 to 0x10; read 0x10 -> 0x1234_5678.
REQ-036 SHALL cover byte/half writes: after REQ-035:
- byte 0xAB to 0x11 -> read 0x10 returns 0x1234_AB78;
- then half 0xCDEF to 0x12 -> 0xCDEF_AB78.
REQ-037 SHALL cover GPIO and unmapped accesses:
- word 0x0000_00FF to 0xE000_0000 -> gpio_out=0x00FF;
- read of 0xE000_0004 returns sw_in zero-extended;
- read of 0xA000_0000 -> 0.
REQ-038 SHALL cover a one-shot countdown:
- CNT_VAL=3, CTRL=01 -> counter0_out rises exactly 3 cycles after the CTRL write edge, and the value holds 0;
- CNT_STAT write 1 -> counter0_out=0 next cycle.
REQ-039 SHALL cover auto-reload and same-cycle clear: CNT_VAL=2, CTRL=11 -> expiry every 2 cycles; a CNT_STAT clear on an expiry cycle leaves counter0_out=1.
REQ-040 SHALL cover reset mid-count: reset low during countdown -> all outputs 0 asynchronously and RAM data preserved; repeat REQ-038 with MIO_COUNTER_EN undefined -> counter0_out stays 0.
